// File: rtl/isram_resp.sv
// Instruction-memory responder: accepts one fetch PC per valid/ready request and
// returns the instruction word after a programmable latency. Optional macro: ISRAM_RAND_DELAY_EN.
module isram_resp #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    output logic [DATA_W-1:0] o_rsp_inst,
    output logic              o_rsp_err,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_pmem_rd,
    output logic [ADDR_W-1:0] o_pmem_addr,
    input  logic [DATA_W-1:0] i_pmem_rdata
);

    localparam logic [DATA_W-1:0] INST_NOP = DATA_W'(32'h0000_0013);

    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_latency_range
        $error("isram_resp: LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rsp_inst;
    logic              r_rsp_err;
    logic              r_rsp_valid;
    logic              r_req_ready;

    logic              w_accept;
    logic              w_to_resp;
    logic              w_aligned;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [3:0]        w_load_cnt;
    logic [DATA_W-1:0] w_rsp_inst_nxt;

    function automatic logic f_is_aligned(input logic [1:0] lsb);
        f_is_aligned = (lsb == 2'b00);
    endfunction

`ifdef ISRAM_RAND_DELAY_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    // LFSR feedback for x^8+x^6+x^5+x^4+1
    always_comb begin
        w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    end

    // Free-running LFSR that picks each transaction's latency
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // Random latency of 1..4 cycles
    always_comb begin
        w_load_cnt = {2'b00, r_lfsr[1:0]};
    end
`else
    // Fixed latency load value
    always_comb begin
        w_load_cnt = 4'(LATENCY - 1);
    end
`endif

    // Handshake and read-address decode
    always_comb begin
        w_accept = (r_state == S_IDLE) && i_req_valid && r_req_ready;
        if (r_state == S_IDLE) begin
            w_rd_addr = i_req_addr;
        end else begin
            w_rd_addr = r_addr;
        end
        w_aligned = f_is_aligned(w_rd_addr[1:0]);
    end

    // Edge that moves the FSM into RESP is the only edge that samples memory
    always_comb begin
        w_to_resp = 1'b0;
        case (r_state)
            S_IDLE:  w_to_resp = w_accept && (w_load_cnt == 4'd0);
            S_WAIT:  w_to_resp = (r_cnt <= 4'd1);
            default: w_to_resp = 1'b0;
        endcase
    end

    // Memory read strobe and response word; misaligned fetches never touch memory
    always_comb begin
        o_pmem_rd   = w_to_resp && w_aligned && !i_rst;
        o_pmem_addr = w_rd_addr;
        if (w_aligned) begin
            w_rsp_inst_nxt = i_pmem_rdata;
        end else begin
            w_rsp_inst_nxt = INST_NOP;
        end
    end

    // Transaction FSM with registered response and handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_rsp_inst  <= INST_NOP;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= i_req_addr;
                        r_cnt       <= w_load_cnt;
                        r_req_ready <= 1'b0;
                        if (w_to_resp) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_inst  <= w_rsp_inst_nxt;
                            r_rsp_err   <= !w_aligned;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_to_resp) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_inst  <= w_rsp_inst_nxt;
                        r_rsp_err   <= !w_aligned;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_RESP: begin
                    // Response fields stay frozen under back-pressure
                    if (r_rsp_valid && i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Drive outputs straight from registers
    always_comb begin
        o_req_ready = r_req_ready;
        o_rsp_inst  = r_rsp_inst;
        o_rsp_err   = r_rsp_err;
        o_rsp_valid = r_rsp_valid;
    end

endmodule

// File: tb/tb_isram_resp.sv
// Directed bench for isram_resp: three instances with LATENCY 1, 3 and 4 share a
// small memory model; with ISRAM_RAND_DELAY_EN the random-latency scenario runs instead.
module tb_isram_resp;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst        [3];
    logic [31:0] req_addr   [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] rsp_inst   [3];
    logic        rsp_err    [3];
    logic        rsp_valid  [3];
    logic        rsp_ready  [3];
    logic        pmem_rd    [3];
    logic [31:0] pmem_addr  [3];
    logic [31:0] pmem_rdata [3];
    int          rd_cnt     [3] = '{0, 0, 0};

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [31:0] pmem_word(input logic [31:0] a);
        case (a)
            32'h8000_0000: pmem_word = 32'h0000_0413;
            32'h8000_0004: pmem_word = 32'h0010_0073;
            32'h8000_0008: pmem_word = 32'h0000_0513;
            default:       pmem_word = a ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign pmem_rdata[0] = pmem_word(pmem_addr[0]);
    assign pmem_rdata[1] = pmem_word(pmem_addr[1]);
    assign pmem_rdata[2] = pmem_word(pmem_addr[2]);

    always @(posedge clk) begin
        if (pmem_rd[0] === 1'b1) rd_cnt[0] <= rd_cnt[0] + 1;
        if (pmem_rd[1] === 1'b1) rd_cnt[1] <= rd_cnt[1] + 1;
        if (pmem_rd[2] === 1'b1) rd_cnt[2] <= rd_cnt[2] + 1;
    end

    isram_resp #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_lat1 (
        .i_clk(clk), .i_rst(rst[0]), .i_req_addr(req_addr[0]), .i_req_valid(req_valid[0]),
        .o_req_ready(req_ready[0]), .o_rsp_inst(rsp_inst[0]), .o_rsp_err(rsp_err[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_pmem_rd(pmem_rd[0]),
        .o_pmem_addr(pmem_addr[0]), .i_pmem_rdata(pmem_rdata[0]));

    isram_resp #(.ADDR_W(32), .DATA_W(32), .LATENCY(3)) u_lat3 (
        .i_clk(clk), .i_rst(rst[1]), .i_req_addr(req_addr[1]), .i_req_valid(req_valid[1]),
        .o_req_ready(req_ready[1]), .o_rsp_inst(rsp_inst[1]), .o_rsp_err(rsp_err[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_pmem_rd(pmem_rd[1]),
        .o_pmem_addr(pmem_addr[1]), .i_pmem_rdata(pmem_rdata[1]));

    isram_resp #(.ADDR_W(32), .DATA_W(32), .LATENCY(4)) u_lat4 (
        .i_clk(clk), .i_rst(rst[2]), .i_req_addr(req_addr[2]), .i_req_valid(req_valid[2]),
        .o_req_ready(req_ready[2]), .o_rsp_inst(rsp_inst[2]), .o_rsp_err(rsp_err[2]),
        .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]), .o_pmem_rd(pmem_rd[2]),
        .o_pmem_addr(pmem_addr[2]), .i_pmem_rdata(pmem_rdata[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; rsp_ready[k] = 1'b1; req_addr[k] = 32'h0;
        end
        repeat (3) tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            vectors += 5;
            if (req_ready[k] !== 1'b1) begin miscompares++; $display("FAIL reset_ready[%0d]: got %b want 1", k, req_ready[k]); end
            if (rsp_valid[k] !== 1'b0) begin miscompares++; $display("FAIL reset_valid[%0d]: got %b want 0", k, rsp_valid[k]); end
            if (rsp_err[k] !== 1'b0)   begin miscompares++; $display("FAIL reset_err[%0d]: got %b want 0", k, rsp_err[k]); end
            if (rsp_inst[k] !== NOP)   begin miscompares++; $display("FAIL reset_inst[%0d]: got %h want %h", k, rsp_inst[k], NOP); end
            if (rd_cnt[k] !== 0)       begin miscompares++; $display("FAIL reset_reads[%0d]: got %0d want 0", k, rd_cnt[k]); end
        end
    endtask

    task automatic test_lat1();
        int c0;
        c0 = rd_cnt[0];
        req_addr[0] = 32'h8000_0000; req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        vectors += 4;
        if (rsp_valid[0] !== 1'b1)          begin miscompares++; $display("FAIL lat1_valid: got %b want 1", rsp_valid[0]); end
        if (rsp_inst[0] !== 32'h0000_0413)  begin miscompares++; $display("FAIL lat1_inst: got %h want 00000413", rsp_inst[0]); end
        if (rsp_err[0] !== 1'b0)            begin miscompares++; $display("FAIL lat1_err: got %b want 0", rsp_err[0]); end
        if (req_ready[0] !== 1'b0)          begin miscompares++; $display("FAIL lat1_busy: got %b want 0", req_ready[0]); end
        tick();
        vectors += 3;
        if (rsp_valid[0] !== 1'b0)  begin miscompares++; $display("FAIL lat1_drop: got %b want 0", rsp_valid[0]); end
        if (req_ready[0] !== 1'b1)  begin miscompares++; $display("FAIL lat1_idle: got %b want 1", req_ready[0]); end
        if (rd_cnt[0] - c0 !== 1)   begin miscompares++; $display("FAIL lat1_reads: got %0d want 1", rd_cnt[0] - c0); end
    endtask

    task automatic test_stall();
        int c0;
        int n;
        int bad;
        c0 = rd_cnt[1];
        req_addr[1] = 32'h8000_0004; req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
        tick();
        req_valid[1] = 1'b0;
        n = 1;
        while (rsp_valid[1] !== 1'b1 && n < 20) begin tick(); n++; end
        vectors++;
        if (n !== 3) begin miscompares++; $display("FAIL stall_latency: got %0d want 3", n); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid[1] !== 1'b1 || rsp_inst[1] !== 32'h0010_0073 || rsp_err[1] !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL stall_hold: got %0d unstable cycles want 0 (inst %h)", bad, rsp_inst[1]); end
        rsp_ready[1] = 1'b1;
        tick();
        vectors += 3;
        if (rsp_valid[1] !== 1'b0) begin miscompares++; $display("FAIL stall_drop: got %b want 0", rsp_valid[1]); end
        if (req_ready[1] !== 1'b1) begin miscompares++; $display("FAIL stall_idle: got %b want 1", req_ready[1]); end
        if (rd_cnt[1] - c0 !== 1)  begin miscompares++; $display("FAIL stall_reads: got %0d want 1", rd_cnt[1] - c0); end
    endtask

    task automatic test_misaligned();
        int c0;
        int n;
        c0 = rd_cnt[1];
        req_addr[1] = 32'h8000_0002; req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
        tick();
        req_valid[1] = 1'b0;
        n = 1;
        while (rsp_valid[1] !== 1'b1 && n < 20) begin tick(); n++; end
        vectors += 4;
        if (n !== 3)              begin miscompares++; $display("FAIL mis_latency: got %0d want 3", n); end
        if (rsp_err[1] !== 1'b1)  begin miscompares++; $display("FAIL mis_err: got %b want 1", rsp_err[1]); end
        if (rsp_inst[1] !== NOP)  begin miscompares++; $display("FAIL mis_inst: got %h want %h", rsp_inst[1], NOP); end
        if (rd_cnt[1] - c0 !== 0) begin miscompares++; $display("FAIL mis_reads: got %0d want 0", rd_cnt[1] - c0); end
        rsp_ready[1] = 1'b1;
        tick();
        vectors++;
        if (req_ready[1] !== 1'b1) begin miscompares++; $display("FAIL mis_idle: got %b want 1", req_ready[1]); end
    endtask

    task automatic test_reset_in_wait();
        int c0;
        int n;
        int seen;
        c0 = rd_cnt[2];
        req_addr[2] = 32'h8000_0000; req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        tick();
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        vectors += 2;
        if (req_ready[2] !== 1'b1) begin miscompares++; $display("FAIL rstwait_ready: got %b want 1", req_ready[2]); end
        if (rsp_valid[2] !== 1'b0) begin miscompares++; $display("FAIL rstwait_valid: got %b want 0", rsp_valid[2]); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid[2] !== 1'b0) seen++;
        end
        vectors += 2;
        if (seen !== 0)           begin miscompares++; $display("FAIL rstwait_ghost: got %0d valid cycles want 0", seen); end
        if (rd_cnt[2] - c0 !== 0) begin miscompares++; $display("FAIL rstwait_reads: got %0d want 0", rd_cnt[2] - c0); end
        req_addr[2] = 32'h8000_0008; req_valid[2] = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        n = 1;
        while (rsp_valid[2] !== 1'b1 && n < 20) begin tick(); n++; end
        vectors += 4;
        if (n !== 4)                       begin miscompares++; $display("FAIL rstwait_latency: got %0d want 4", n); end
        if (rsp_inst[2] !== 32'h0000_0513) begin miscompares++; $display("FAIL rstwait_inst: got %h want 00000513", rsp_inst[2]); end
        if (rsp_err[2] !== 1'b0)           begin miscompares++; $display("FAIL rstwait_err: got %b want 0", rsp_err[2]); end
        if (rd_cnt[2] - c0 !== 1)          begin miscompares++; $display("FAIL rstwait_reads2: got %0d want 1", rd_cnt[2] - c0); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4] = '{32'h8000_0010, 32'h8000_0014, 32'h8000_0018, 32'h8000_001C};
        logic [31:0] words [4] = '{32'hDA5A_0F1F, 32'hDA5A_0F1B, 32'hDA5A_0F17, 32'hDA5A_0F13};
        int c0;
        c0 = rd_cnt[0];
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr[0] = addrs[i]; req_valid[0] = 1'b1;
            tick();
            vectors += 2;
            if (rsp_valid[0] !== 1'b1)    begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, rsp_valid[0]); end
            if (rsp_inst[0] !== words[i]) begin miscompares++; $display("FAIL b2b_inst[%0d]: got %h want %h", i, rsp_inst[0], words[i]); end
            if (i < 3) req_addr[0] = addrs[i + 1];
            else req_valid[0] = 1'b0;
            tick();
            vectors++;
            if (req_ready[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_gap[%0d]: got %b want 1", i, req_ready[0]); end
        end
        vectors++;
        if (rd_cnt[0] - c0 !== 4) begin miscompares++; $display("FAIL b2b_reads: got %0d want 4", rd_cnt[0] - c0); end
    endtask

    task automatic run_random(output int lats [100]);
        int n;
        logic [31:0] a;
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 32'h8000_1000 + 32'(i * 4);
            req_addr[0] = a; req_valid[0] = 1'b1;
            tick();
            req_valid[0] = 1'b0;
            n = 1;
            while (rsp_valid[0] !== 1'b1 && n < 20) begin tick(); n++; end
            lats[i] = n;
            vectors += 2;
            if (n < 1 || n > 4)              begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d want 1..4", i, n); end
            if (rsp_inst[0] !== pmem_word(a)) begin miscompares++; $display("FAIL rand_inst[%0d]: got %h want %h", i, rsp_inst[0], pmem_word(a)); end
            tick();
        end
    endtask

    task automatic test_rand_delay();
        int run1 [100];
        int run2 [100];
        int diff;
        do_reset();
        run_random(run1);
        do_reset();
        run_random(run2);
        diff = 0;
        for (int i = 0; i < 100; i++) if (run1[i] != run2[i]) diff++;
        vectors++;
        if (diff !== 0) begin miscompares++; $display("FAIL rand_repeat: got %0d differing latencies want 0", diff); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; rsp_ready[k] = 1'b0; req_addr[k] = 32'h0;
        end
        test_reset();
`ifdef ISRAM_RAND_DELAY_EN
        test_rand_delay();
`else
        test_lat1();
        test_stall();
        test_misaligned();
        test_reset_in_wait();
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
